reg_file_mrnw: RTL and testbench

//  Parametrised multi-read / multi-write register file; successor of the fixed 2R1W file.

---
 rtl/reg_file_pkg.sv | 21 ++
 rtl/reg_file_mrnw_if.sv | 36 +++
 rtl/reg_file_clr_fsm.sv | 73 +++++++
 rtl/reg_file_mrnw.sv | 129 ++++++++++++
 tb/tb_reg_file_mrnw.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// ----------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the multi-read / multi-write register file:
//   - clear-sequencer state encoding (RF_CLEAR, RF_READY) and its enum type
//   - port-count limits for the NUM_RD / NUM_WR parameters
// ----------------------------------------------------------------------------
package reg_file_pkg;

    localparam logic RF_CLEAR = 1'b0;
    localparam logic RF_READY = 1'b1;

    // Largest supported port counts.
    localparam int RF_MAX_RD = 8;
    localparam int RF_MAX_WR = 4;

    typedef enum logic {
        ST_CLEAR = RF_CLEAR,
        ST_READY = RF_READY
    } rf_state_e;

endpackage

// File: rtl/reg_file_mrnw_if.sv
// ----------------------------------------------------------------------------
// reg_file_mrnw_if
// Bus bundle between the pipeline and the register file.
//   clr_req      : request a clear sweep
//   ready        : file usable (low while sweeping)
//   rd_en/rd_addr/rd_data : NUM_RD packed read ports
//   wr_en/wr_addr/wr_data : NUM_WR packed write ports
//   wr_conflict  : pulse when enabled write ports collided on one address
// master = pipeline side, slave = register file side.
// ----------------------------------------------------------------------------
interface reg_file_mrnw_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1
);
    logic                         clr_req;
    logic                         ready;
    logic [NUM_RD-1:0]            rd_en;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic                         wr_conflict;

    modport master (
        output clr_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  ready, rd_data, wr_conflict
    );

    modport slave (
        input  clr_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output ready, rd_data, wr_conflict
    );
endinterface

// File: rtl/reg_file_clr_fsm.sv
// ----------------------------------------------------------------------------
// reg_file_clr_fsm
// Clear sequencer: after reset, or on clr_req while READY, sweeps every entry
// from 0 to DEPTH-1 writing zero, one entry per clock.
//   clk, rst  : clock, asynchronous active-high reset
//   clr_req   : start a sweep (only looked at in READY)
//   ready     : registered, 1 once the sweep has cleared the last entry
//   clr_we    : 1 while sweeping; the top writes zero to clr_addr
//   clr_addr  : entry being cleared this cycle
// ----------------------------------------------------------------------------
module reg_file_clr_fsm
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  ready,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    rf_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  ready_q, ready_d;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        ready_d    = ready_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_addr_q == '1) begin
                    // Last entry cleared this edge; the counter parks here.
                    state_d = ST_READY;
                    ready_d = 1'b1;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                    ready_d    = 1'b0;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
                ready_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ready_q    <= ready_d;
        end
    end

    assign ready    = ready_q;
    assign clr_we   = (state_q == ST_CLEAR);
    assign clr_addr = clr_addr_q;

endmodule

// File: rtl/reg_file_mrnw.sv
// ----------------------------------------------------------------------------
// reg_file_mrnw
// Parametrised NUM_RD-read / NUM_WR-write register file with optional
// hardwired-zero entry 0, optional write-to-read bypass and a hardware clear
// sweep after reset or on request.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : reg_file_mrnw_if.slave (clr_req, ready, read ports with
//              registered rd_data, write ports, wr_conflict pulse)
// Several enabled writes to one address: the highest port index wins.
// ----------------------------------------------------------------------------
module reg_file_mrnw
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic             clk,
    input  logic             rst,
    reg_file_mrnw_if.slave   bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    logic [ADDR_WIDTH-1:0] rd_addr_a [NUM_RD];
    logic [ADDR_WIDTH-1:0] wr_addr_a [NUM_WR];
    logic [DATA_WIDTH-1:0] wr_data_a [NUM_WR];
    logic [NUM_WR-1:0]     wr_valid;

    logic [DATA_WIDTH-1:0] rd_data_q [NUM_RD];
    logic [DATA_WIDTH-1:0] rd_data_d [NUM_RD];
    logic                  wr_conflict_q, wr_conflict_d;

    reg_file_clr_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (bus.clr_req),
        .ready    (bus.ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
            assign rd_addr_a[gi] = bus.rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign bus.rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = rd_data_q[gi];
        end
        for (gi = 0; gi < NUM_WR; gi++) begin : g_wr_port
            assign wr_addr_a[gi] = bus.wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wr_data_a[gi] = bus.wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
            // A write counts only outside the sweep and, with the hardwired
            // zero entry, only when it does not target entry 0.
            assign wr_valid[gi]  = bus.wr_en[gi] && !clr_we &&
                                   !((ZERO_REG != 0) && (wr_addr_a[gi] == '0));
        end
    endgenerate

    // Any pair of valid writes on the same address is a conflict.
    always_comb begin
        wr_conflict_d = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (wr_valid[j] && wr_valid[k] && (wr_addr_a[j] == wr_addr_a[k])) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    // Read path: ascending port scan so the highest-index matching write
    // is the one forwarded, matching the array's write priority.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data_d[i] = rd_data_q[i];
            if (bus.rd_en[i]) begin
                if (clr_we || ((ZERO_REG != 0) && (rd_addr_a[i] == '0))) begin
                    rd_data_d[i] = '0;
                end else begin
                    rd_data_d[i] = mem[rd_addr_a[i]];
                    if (BYPASS != 0) begin
                        for (int j = 0; j < NUM_WR; j++) begin
                            if (wr_valid[j] && (wr_addr_a[j] == rd_addr_a[i])) begin
                                rd_data_d[i] = wr_data_a[j];
                            end
                        end
                    end
                end
            end
        end
    end

    // Storage array: no reset, the clear sweep zeroes it. Later ports
    // overwrite earlier ones, giving the highest index priority.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_valid[j]) begin
                    mem[wr_addr_a[j]] <= wr_data_a[j];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_data_q[i] <= '0;
            end
            wr_conflict_q <= 1'b0;
        end else begin
            rd_data_q     <= rd_data_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign bus.wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_reg_file_mrnw.sv
// ----------------------------------------------------------------------------
// tb_reg_file_mrnw
// Two instances share one stimulus stream:
//   dut_a : NUM_WR=2, ZERO_REG=1, BYPASS=1
//   dut_b : NUM_WR=2, ZERO_REG=0, BYPASS=0
// A behavioural model (per-address write map, sweep counter) tracks both.
// ----------------------------------------------------------------------------
module tb_reg_file_mrnw;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          clr_req;
    logic [NR-1:0] rd_en;
    logic [NW-1:0] wr_en;
    logic [AW-1:0] ra [NR];
    logic [AW-1:0] wa [NW];
    logic [DW-1:0] wd [NW];

    reg_file_mrnw_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) if_a ();
    reg_file_mrnw_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) if_b ();

    assign if_a.clr_req = clr_req;
    assign if_a.rd_en   = rd_en;
    assign if_a.rd_addr = {ra[1], ra[0]};
    assign if_a.wr_en   = wr_en;
    assign if_a.wr_addr = {wa[1], wa[0]};
    assign if_a.wr_data = {wd[1], wd[0]};
    assign if_b.clr_req = clr_req;
    assign if_b.rd_en   = rd_en;
    assign if_b.rd_addr = {ra[1], ra[0]};
    assign if_b.wr_en   = wr_en;
    assign if_b.wr_addr = {wa[1], wa[0]};
    assign if_b.wr_data = {wd[1], wd[0]};

    reg_file_mrnw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW),
                    .ZERO_REG(1), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    reg_file_mrnw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW),
                    .ZERO_REG(0), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [2][DEPTH];
    logic [DW-1:0] m_rd  [2][NR];
    logic          m_conf[2];
    bit            m_ready;
    int            m_sweep;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] rdo(input int c, input int i);
        if (c == 0) return if_a.rd_data[i*DW +: DW];
        return if_b.rd_data[i*DW +: DW];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < NR; i++) m_rd[c][i] = '0;
            m_conf[c] = 1'b0;
        end
        m_ready = 1'b0;
        m_sweep = 0;
    endtask

    // One clock edge using the inputs present at that edge.
    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 2; c++) begin
            bit            zr;
            bit            by;
            logic [DW-1:0] nxt [DEPTH];
            int            cnt [DEPTH];
            zr = (c == 0);
            by = (c == 0);
            if (!m_ready) begin
                for (int i = 0; i < NR; i++) if (rd_en[i]) m_rd[c][i] = '0;
                m_conf[c] = 1'b0;
                m_mem[c][m_sweep] = '0;
            end else begin
                for (int a = 0; a < DEPTH; a++) begin cnt[a] = 0; nxt[a] = '0; end
                for (int j = 0; j < NW; j++) begin
                    if (wr_en[j] && !(zr && wa[j] == 0)) begin
                        cnt[wa[j]]++;
                        nxt[wa[j]] = wd[j];
                    end
                end
                m_conf[c] = 1'b0;
                for (int a = 0; a < DEPTH; a++) if (cnt[a] > 1) m_conf[c] = 1'b1;
                for (int i = 0; i < NR; i++) begin
                    if (rd_en[i]) begin
                        if (zr && ra[i] == 0)          m_rd[c][i] = '0;
                        else if (by && cnt[ra[i]] > 0) m_rd[c][i] = nxt[ra[i]];
                        else                           m_rd[c][i] = m_mem[c][ra[i]];
                    end
                end
                for (int a = 0; a < DEPTH; a++) if (cnt[a] > 0) m_mem[c][a] = nxt[a];
            end
        end
        if (!m_ready) begin
            m_sweep++;
            if (m_sweep == DEPTH) m_ready = 1'b1;
        end else if (clr_req) begin
            m_ready = 1'b0;
            m_sweep = 0;
        end
    endtask

    task automatic compare_all();
        chk("a.ready", {31'd0, if_a.ready}, {31'd0, m_ready});
        chk("b.ready", {31'd0, if_b.ready}, {31'd0, m_ready});
        chk("a.conflict", {31'd0, if_a.wr_conflict}, {31'd0, m_conf[0]});
        chk("b.conflict", {31'd0, if_b.wr_conflict}, {31'd0, m_conf[1]});
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("a.rd%0d", i), rdo(0, i), m_rd[0][i]);
            chk($sformatf("b.rd%0d", i), rdo(1, i), m_rd[1][i]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        clr_req = 1'b0;
        rd_en   = '0;
        wr_en   = '0;
        for (int i = 0; i < NR; i++) ra[i] = '0;
        for (int j = 0; j < NW; j++) begin wa[j] = '0; wd[j] = '0; end
    endtask

    // Cycles until ready rises, bounded.
    task automatic cycles_to_ready(input bit rand_writes, output int n);
        n = 0;
        while (!if_a.ready && n < 100) begin
            if (rand_writes) begin
                wr_en = 2'b11;
                for (int j = 0; j < NW; j++) begin
                    wa[j] = AW'($urandom_range(1, 4));
                    wd[j] = $urandom;
                end
            end
            cycle();
            n++;
        end
        wr_en = '0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] a0, a1, b0, b1;
        logic        ca, cb;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int n;
        tbl[0] = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b11, 5'd1, 5'd2,
                   32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[1] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd5,
                   32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[2] = '{2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 2'b11, 5'd7, 5'd7,
                   32'h22, 32'h22, 32'h0, 32'h0, 1'b1, 1'b1};
        tbl[3] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd5,
                   32'h22, 32'hDEADBEEF, 32'h22, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[4] = '{2'b01, 5'd3, 32'h55, 5'd0, 32'h0, 2'b11, 5'd3, 5'd3,
                   32'h55, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[5] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd9,
                   32'h55, 32'h0, 32'h55, 32'h0, 1'b0, 1'b0};
        tbl[6] = '{2'b11, 5'd0, 32'hFFFF, 5'd0, 32'h1234, 2'b11, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1};
        tbl[7] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'h1234, 32'h1234, 1'b0, 1'b0};
        tbl[8] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd3, 5'd5,
                   32'h55, 32'h0, 32'h55, 32'h1234, 1'b0, 1'b0};
        tbl[9] = '{2'b01, 5'd9, 32'hA, 5'd0, 32'h0, 2'b11, 5'd9, 5'd9,
                   32'hA, 32'hA, 32'h0, 32'h0, 1'b0, 1'b0};

        idle_inputs();
        model_reset();
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < DEPTH; a++) m_mem[c][a] = '0;

        // Reset state, then the power-on sweep.
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        $display("reset: ready=%b rd0=%h conflict=%b", if_a.ready, rdo(0, 0), if_a.wr_conflict);
        rst = 1'b0;
        cycles_to_ready(1'b0, n);
        chk("reset_sweep_edges", n, 32);
        $display("reset sweep: ready after %0d edges", n);

        // Any address reads 0 after the sweep.
        for (int k = 0; k < 4; k++) begin
            rd_en = 2'b11;
            ra[0] = AW'($urandom_range(0, 31));
            ra[1] = AW'($urandom_range(0, 31));
            cycle();
            chk("post_reset_rd0", rdo(0, 0), 32'h0);
            chk("post_reset_rd1", rdo(1, 1), 32'h0);
            $display("post-reset read %0d,%0d -> %h %h", ra[0], ra[1], rdo(0, 0), rdo(0, 1));
        end

        // Directed vectors.
        for (int v = 0; v < 10; v++) begin
            wr_en = tbl[v].we;
            wa[0] = tbl[v].wa0; wd[0] = tbl[v].wd0;
            wa[1] = tbl[v].wa1; wd[1] = tbl[v].wd1;
            rd_en = tbl[v].re;
            ra[0] = tbl[v].ra0; ra[1] = tbl[v].ra1;
            cycle();
            chk($sformatf("vec%0d.a0", v), rdo(0, 0), tbl[v].a0);
            chk($sformatf("vec%0d.a1", v), rdo(0, 1), tbl[v].a1);
            chk($sformatf("vec%0d.b0", v), rdo(1, 0), tbl[v].b0);
            chk($sformatf("vec%0d.b1", v), rdo(1, 1), tbl[v].b1);
            chk($sformatf("vec%0d.ca", v), {31'd0, if_a.wr_conflict}, {31'd0, tbl[v].ca});
            chk($sformatf("vec%0d.cb", v), {31'd0, if_b.wr_conflict}, {31'd0, tbl[v].cb});
            $display("vec %0d: we=%b re=%b a=%h/%h b=%h/%h conf=%b%b", v, wr_en, rd_en,
                     rdo(0, 0), rdo(0, 1), rdo(1, 0), rdo(1, 1), if_a.wr_conflict, if_b.wr_conflict);
        end
        idle_inputs();

        // Randomised traffic against the model.
        for (int k = 0; k < 300; k++) begin
            wr_en   = NW'($urandom_range(0, 3));
            rd_en   = NR'($urandom_range(0, 3));
            clr_req = ($urandom_range(0, 63) == 0);
            for (int j = 0; j < NW; j++) begin wa[j] = AW'($urandom_range(0, 7)); wd[j] = $urandom; end
            for (int i = 0; i < NR; i++) ra[i] = AW'($urandom_range(0, 7));
            cycle();
            $display("rand %0d: we=%b wa=%0d,%0d re=%b ra=%0d,%0d clr=%b a=%h/%h b=%h/%h", k, wr_en,
                     wa[0], wa[1], rd_en, ra[0], ra[1], clr_req, rdo(0, 0), rdo(0, 1), rdo(1, 0), rdo(1, 1));
        end
        idle_inputs();
        cycles_to_ready(1'b0, n);
        chk("ready_before_clear_test", {31'd0, if_a.ready}, 32'd1);

        // Fill four entries, then request a clear with writes during the sweep.
        for (int k = 1; k <= 4; k++) begin
            wr_en = 2'b01; wa[0] = AW'(k); wd[0] = 32'h100 + k;
            cycle();
            $display("fill entry %0d", k);
        end
        wr_en = '0;
        rd_en = 2'b11; ra[0] = 5'd1; ra[1] = 5'd4;
        cycle();
        chk("fill_rd0", rdo(0, 0), 32'h101);
        chk("fill_rd1", rdo(1, 1), 32'h104);
        rd_en = '0;
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        chk("clr_ready_low", {31'd0, if_a.ready}, 32'd0);
        cycles_to_ready(1'b1, n);
        chk("clr_sweep_edges", n, 32);
        $display("clear sweep: ready after %0d edges", n);
        for (int a = 0; a < DEPTH; a += 2) begin
            rd_en = 2'b11; ra[0] = AW'(a); ra[1] = AW'(a + 1);
            cycle();
            chk($sformatf("cleared_b%0d", a), rdo(1, 0), 32'h0);
            chk($sformatf("cleared_b%0d", a + 1), rdo(1, 1), 32'h0);
            $display("after clear: entries %0d,%0d -> %h %h", a, a + 1, rdo(1, 0), rdo(1, 1));
        end

        // Reset in the middle of a sweep.
        wr_en = 2'b01; wa[0] = 5'd6; wd[0] = 32'hCAFE; rd_en = '0;
        cycle();
        wr_en = '0; rd_en = 2'b11; ra[0] = 5'd6; ra[1] = 5'd6;
        cycle();
        chk("pre_rst_rd", rdo(0, 0), 32'hCAFE);
        rd_en = '0; clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        repeat (10) cycle();
        chk("mid_sweep_hold", rdo(1, 1), 32'hCAFE);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_a_rd0", rdo(0, 0), 32'h0);
        chk("async_rst_b_rd1", rdo(1, 1), 32'h0);
        chk("async_rst_ready", {31'd0, if_a.ready}, 32'd0);
        $display("mid-sweep reset: rd=%h ready=%b", rdo(0, 0), if_a.ready);
        cycle();
        cycle();
        rst = 1'b0;
        cycles_to_ready(1'b0, n);
        chk("restart_sweep_edges", n, 32);
        rd_en = 2'b11; ra[0] = 5'd6; ra[1] = 5'd6;
        cycle();
        chk("after_restart_rd", rdo(1, 0), 32'h0);
        $display("restart sweep: ready after %0d edges, entry 6 = %h", n, rdo(1, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
